// File: rtl/power_unit.sv
// power_unit: sequential signed integer power, result = base**exp truncated
// to 8 bits two's complement. One multiply per cycle, with a sticky overflow
// flag that reports whether any intermediate product left the 8-bit range.
module power_unit #(
    parameter int EXP_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [7:0]       base,
    input  logic        [EXP_W-1:0] exp,
    output logic signed [7:0]       result,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic signed [7:0]      acc_r;
    logic signed [7:0]      base_r;
    logic [EXP_W-1:0]       cnt_r;
    logic                   ovf_r;
    logic                   busy_r;
    logic                   done_r;
    logic signed [15:0]     prod_s;
    logic                   prod_ovf_s;

    // True when a 16-bit product cannot be represented in signed 8 bits.
    // -128 is representable and therefore not an overflow.
    function automatic logic out_of_range(input logic signed [15:0] p);
        return (p < -16'sd128) || (p > 16'sd127);
    endfunction

    // Full-width signed product of the running accumulator and the latched base.
    always_comb begin
        prod_s     = {{8{acc_r[7]}}, acc_r} * {{8{base_r[7]}}, base_r};
        prod_ovf_s = out_of_range(prod_s);
    end

    // Control FSM and datapath registers; busy/done are registered alongside state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= 8'sd0;
            base_r  <= 8'sd0;
            cnt_r   <= {EXP_W{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        base_r <= base;
                        cnt_r  <= exp;
                        acc_r  <= 8'sd1;
                        ovf_r  <= 1'b0;
                        if (exp != {EXP_W{1'b0}}) begin
                            state_r <= CALC;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    acc_r <= prod_s[7:0];
                    ovf_r <= ovf_r | prod_ovf_s;
                    cnt_r <= cnt_r - {{(EXP_W-1){1'b0}}, 1'b1};
                    // Leave on the last multiply so cnt never wraps past zero.
                    if (cnt_r == {{(EXP_W-1){1'b0}}, 1'b1}) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result = acc_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign ovf    = ovf_r;

endmodule
